reorder_buffer: RTL and testbench
=================================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; ports: clk in 1 (rising-edge clock); reset in 1 (sync active-high, also driven high on mispredict flush).
REQ-002 The block SHALL have these parameters: DEPTH, 16, entry count, tag width 4, fixed; DATA_W, 32, result width.
REQ-003 The block SHALL have these issue ports: issue_valid in 1 (instruction offered); issue_writes in 1 (writes rd); issue_dest in 5 (rd); issue_is_store in 1; stall in 1 (blocks allocation); issue_ROB out 4 (tag = tail); rob_full out 1.
REQ-004 The block SHALL have these writeback ports: cdb_valid in 1; cdb_ROB in 4; cdb_value in 32; cdb_mispredict in 1 (branch resolved wrong).
REQ-005 The block SHALL have these commit ports: commit_valid out 1; commit_ROB out 4; commit_dest out 5; RegWrite out 1; commit_value out 32; mem_commit out 1 (store retires); flush out 1 (mispredicted branch retiring).
REQ-006 The block SHALL have these lookup ports: lk_tag_j, lk_tag_k in 4; lk_ready_j, lk_ready_k out 1; lk_value_j, lk_value_k out 32.

Function
REQ-007 Entry fields SHALL be: valid, done, writes, is_store, mispredict, dest[4:0], value[31:0].
REQ-008 State SHALL be: head[3:0], tail[3:0], count[4:0] (0..16); rob_full = (count == 16).
REQ-009 Allocation SHALL occur when issue_valid & ~stall & ~rob_full & ~flush; at the edge the tail entry SHALL be written (valid=1, done=0, mispredict=0, fields from issue ports) and tail SHALL increment mod 16.
REQ-010 issue_ROB SHALL equal tail combinationally, with no latency; the issue stage captures it in the same cycle.
REQ-011 When cdb_valid is high and entry cdb_ROB is valid, done, value and mispredict SHALL be set at the edge; a writeback to an invalid entry SHALL be ignored.
REQ-012 commit_valid SHALL be combinational: high when count != 0 and head entry done; commit_ROB = head; commit_dest, commit_value from head.
REQ-013 RegWrite = commit_valid & head.writes & (commit_dest != 0); mem_commit = commit_valid & head.is_store.
REQ-014 On commit the head entry valid SHALL clear and head SHALL increment mod 16 at the edge; stall SHALL NOT block commit.
REQ-015 Simultaneous allocate and commit SHALL leave count unchanged; allocate only: +1; commit only: -1.
REQ-016 When full, allocation SHALL be refused even if a commit occurs the same cycle.
REQ-017 flush = commit_valid & head.mispredict; the committing branch's outputs SHALL be presented that cycle; at the edge all valid bits, head, tail and count SHALL clear and any offered issue SHALL be dropped.
REQ-018 A writeback and commit of the same entry SHALL NOT be possible in one cycle (done is registered); commit SHALL occur at the earliest one cycle after writeback.
REQ-019 Tag wrap SHALL be seamless: tail 15 -> 0 and head 15 -> 0.

Reset
REQ-020 On reset, head=0, tail=0, count=0, and all valid/done bits SHALL be 0; the resulting outputs are commit_valid=0, RegWrite=0, mem_commit=0, flush=0, rob_full=0, issue_ROB=0, lk_ready_*=0.
REQ-021 Reset SHALL take priority over allocation, writeback and commit in the same cycle.

Configuration
REQ-022 With macro ROB_OPERAND_BYPASS_EN defined, lk_ready_x SHALL equal valid & done of entry lk_tag_x and lk_value_x SHALL equal its value, from registered state only (no same-cycle CDB forward).
REQ-023 Without ROB_OPERAND_BYPASS_EN, lk_ready_* and lk_value_* SHALL be tied to 0 and no lookup muxes SHALL be built.

Verification
REQ-024 Reset, then issue x5 (writes) -> issue_ROB=0; next cycle issue_ROB=1; CDB tag0 value 0xAB -> next cycle commit_valid=1, commit_dest=5, RegWrite=1, commit_value=0xAB.
REQ-025 Issue 16 without writeback -> rob_full=1 and issue_ROB=0; 17th issue ignored; CDB tag0 then commit -> count=15, next allocation gets tag 0.
REQ-026 Writeback tags 2,1 out of order before tag 0 -> no commit until tag 0 done; then tags 0,1,2 commit on three consecutive cycles.
REQ-027 Branch tag 3 with cdb_mispredict=1 while tags 4..6 are in flight -> on its commit flush=1 for one cycle; next cycle count=0, issue_ROB=0, commit_valid=0.
REQ-028 Store tag 0 done -> mem_commit=1, RegWrite=0; writes to x0 -> RegWrite=0.
REQ-029 With ROB_OPERAND_BYPASS_EN, lk_tag_j=tag of a done entry -> lk_ready_j=1 and value matches; without the macro -> 0.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: 16-entry circular queue that allocates at issue, collects
// results from the CDB and retires in program order. A mispredicted branch
// reaching the head raises flush and empties the buffer.
// Optional feature: define ROB_OPERAND_BYPASS_EN to build the operand lookup
// ports; otherwise they are tied to zero and no lookup muxes exist.
module reorder_buffer #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 32,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  // issue
  input  logic              issue_valid,
  input  logic              issue_writes,
  input  logic [4:0]        issue_dest,
  input  logic              issue_is_store,
  input  logic              stall,
  output logic [TAG_W-1:0]  issue_ROB,
  output logic              rob_full,
  // writeback
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_ROB,
  input  logic [DATA_W-1:0] cdb_value,
  input  logic              cdb_mispredict,
  // commit
  output logic              commit_valid,
  output logic [TAG_W-1:0]  commit_ROB,
  output logic [4:0]        commit_dest,
  output logic              RegWrite,
  output logic [DATA_W-1:0] commit_value,
  output logic              mem_commit,
  output logic              flush,
  // operand lookup
  input  logic [TAG_W-1:0]  lk_tag_j,
  input  logic [TAG_W-1:0]  lk_tag_k,
  output logic              lk_ready_j,
  output logic              lk_ready_k,
  output logic [DATA_W-1:0] lk_value_j,
  output logic [DATA_W-1:0] lk_value_k
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              writes;
    logic              is_store;
    logic              mispredict;
    logic [4:0]        dest;
    logic [DATA_W-1:0] value;
  } rob_entry_t;

  rob_entry_t       rob [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;
  logic [TAG_W:0]   count;
  logic             alloc;

  // Status, issue tag and head-of-queue commit outputs (all combinational)
  always_comb begin
    rob_full     = (count == FULL_COUNT);
    issue_ROB    = tail;
    commit_valid = (count != '0) && rob[head].done;
    commit_ROB   = head;
    commit_dest  = rob[head].dest;
    commit_value = rob[head].value;
    RegWrite     = commit_valid && rob[head].writes && (rob[head].dest != 5'd0);
    mem_commit   = commit_valid && rob[head].is_store;
    flush        = commit_valid && rob[head].mispredict;
    alloc        = issue_valid && !stall && !rob_full && !flush;
  end

  // Queue state: reset/flush clear, else writeback, commit and allocate
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      // a retiring mispredict empties the buffer exactly like reset
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        rob[i].valid      <= 1'b0;
        rob[i].done       <= 1'b0;
        rob[i].mispredict <= 1'b0;
      end
    end else begin
      if (cdb_valid && rob[cdb_ROB].valid) begin
        rob[cdb_ROB].done       <= 1'b1;
        rob[cdb_ROB].value      <= cdb_value;
        rob[cdb_ROB].mispredict <= cdb_mispredict;
      end
      if (commit_valid) begin
        rob[head].valid <= 1'b0;
        rob[head].done  <= 1'b0;
        head            <= head + TAG_W'(1);
      end
      // the tail slot is never valid while allocating, so no writeback overlap
      if (alloc) begin
        rob[tail].valid      <= 1'b1;
        rob[tail].done       <= 1'b0;
        rob[tail].mispredict <= 1'b0;
        rob[tail].writes     <= issue_writes;
        rob[tail].is_store   <= issue_is_store;
        rob[tail].dest       <= issue_dest;
        tail                 <= tail + TAG_W'(1);
      end
      case ({alloc, commit_valid})
        2'b10:   count <= count + (TAG_W+1)'(1);
        2'b01:   count <= count - (TAG_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef ROB_OPERAND_BYPASS_EN
  // Operand lookup from registered entry state only
  always_comb begin
    lk_ready_j = rob[lk_tag_j].valid && rob[lk_tag_j].done;
    lk_ready_k = rob[lk_tag_k].valid && rob[lk_tag_k].done;
    lk_value_j = rob[lk_tag_j].value;
    lk_value_k = rob[lk_tag_k].value;
  end
`else
  logic unused_lk_tags;

  // Lookup disabled: outputs held at zero
  always_comb begin
    lk_ready_j     = 1'b0;
    lk_ready_k     = 1'b0;
    lk_value_j     = '0;
    lk_value_k     = '0;
    unused_lk_tags = ^{lk_tag_j, lk_tag_k};
  end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by a
// randomized phase, all compared against a queue-based reference model.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid, issue_writes, issue_is_store, stall;
  logic [4:0]  issue_dest;
  logic [3:0]  issue_ROB;
  logic        rob_full;
  logic        cdb_valid, cdb_mispredict;
  logic [3:0]  cdb_ROB;
  logic [31:0] cdb_value;
  logic        commit_valid, RegWrite, mem_commit, flush;
  logic [3:0]  commit_ROB;
  logic [4:0]  commit_dest;
  logic [31:0] commit_value;
  logic [3:0]  lk_tag_j, lk_tag_k;
  logic        lk_ready_j, lk_ready_k;
  logic [31:0] lk_value_j, lk_value_k;

  int checks = 0;
  int errors = 0;

  reorder_buffer #(.DEPTH(16), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_writes(issue_writes), .issue_dest(issue_dest),
    .issue_is_store(issue_is_store), .stall(stall), .issue_ROB(issue_ROB), .rob_full(rob_full),
    .cdb_valid(cdb_valid), .cdb_ROB(cdb_ROB), .cdb_value(cdb_value), .cdb_mispredict(cdb_mispredict),
    .commit_valid(commit_valid), .commit_ROB(commit_ROB), .commit_dest(commit_dest),
    .RegWrite(RegWrite), .commit_value(commit_value), .mem_commit(mem_commit), .flush(flush),
    .lk_tag_j(lk_tag_j), .lk_tag_k(lk_tag_k), .lk_ready_j(lk_ready_j), .lk_ready_k(lk_ready_k),
    .lk_value_j(lk_value_j), .lk_value_k(lk_value_k)
  );

  always #5 clk = ~clk;

  // Reference model: in-flight instructions in program order
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  dest;
    bit          writes;
    bit          is_store;
    bit          done;
    bit          mis;
    logic [31:0] value;
  } ent_t;

  ent_t       q[$];
  logic [3:0] m_tail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_lookup(input logic [3:0] t, output bit rdy, output logic [31:0] val);
    rdy = 1'b0;
    val = '0;
`ifdef ROB_OPERAND_BYPASS_EN
    foreach (q[i]) if (q[i].tag == t && q[i].done) begin
      rdy = 1'b1;
      val = q[i].value;
    end
`endif
  endtask

  task automatic check_outputs();
    bit          cv;
    bit          rdy;
    logic [31:0] val;
    cv = (q.size() != 0) && q[0].done;
    chk("commit_valid", commit_valid, cv);
    chk("rob_full", rob_full, q.size() == 16);
    chk("issue_ROB", issue_ROB, m_tail);
    if (cv) begin
      chk("commit_ROB", commit_ROB, q[0].tag);
      chk("commit_dest", commit_dest, q[0].dest);
      chk("commit_value", commit_value, q[0].value);
      chk("RegWrite", RegWrite, q[0].writes && q[0].dest != 0);
      chk("mem_commit", mem_commit, q[0].is_store);
      chk("flush", flush, q[0].mis);
    end else begin
      chk("RegWrite_idle", RegWrite, 0);
      chk("mem_commit_idle", mem_commit, 0);
      chk("flush_idle", flush, 0);
    end
    model_lookup(lk_tag_j, rdy, val);
    chk("lk_ready_j", lk_ready_j, rdy);
    if (rdy) chk("lk_value_j", lk_value_j, val);
    model_lookup(lk_tag_k, rdy, val);
    chk("lk_ready_k", lk_ready_k, rdy);
    if (rdy) chk("lk_value_k", lk_value_k, val);
  endtask

  task automatic model_step();
    int   n;
    bit   cm;
    ent_t e;
    if (reset) begin
      q.delete();
      m_tail = 0;
      return;
    end
    n  = q.size();
    cm = (n != 0) && q[0].done;
    if (cm && q[0].mis) begin
      q.delete();
      m_tail = 0;
      return;
    end
    if (cdb_valid) foreach (q[i]) if (q[i].tag == cdb_ROB) begin
      q[i].done  = 1'b1;
      q[i].value = cdb_value;
      q[i].mis   = cdb_mispredict;
    end
    if (cm) void'(q.pop_front());
    if (issue_valid && !stall && n < 16) begin
      e.tag = m_tail; e.dest = issue_dest; e.writes = issue_writes;
      e.is_store = issue_is_store; e.done = 1'b0; e.mis = 1'b0; e.value = '0;
      q.push_back(e);
      m_tail = m_tail + 4'd1;
    end
  endtask

  task automatic cycle();
    #1;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 0; issue_valid = 0; issue_writes = 0; issue_dest = 0; issue_is_store = 0;
    stall = 0; cdb_valid = 0; cdb_ROB = 0; cdb_value = 0; cdb_mispredict = 0;
  endtask

  task automatic set_issue(input bit wr, input logic [4:0] d, input bit st);
    issue_valid = 1; issue_writes = wr; issue_dest = d; issue_is_store = st;
  endtask

  task automatic set_cdb(input logic [3:0] t, input logic [31:0] v, input bit mis);
    cdb_valid = 1; cdb_ROB = t; cdb_value = v; cdb_mispredict = mis;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    idle();
  endtask

  initial begin
    idle();
    lk_tag_j = 0;
    lk_tag_k = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    m_tail = 0;
    idle();

    // Reset state
    cycle();
    chk("rst_commit_valid", commit_valid, 0);
    chk("rst_issue_ROB", issue_ROB, 0);
    chk("rst_rob_full", rob_full, 0);

    // Basic issue -> writeback -> commit
    set_issue(1, 5'd5, 0);
    chk("basic_issue_tag0", issue_ROB, 0);
    cycle();
    idle();
    chk("basic_issue_tag1", issue_ROB, 1);
    set_cdb(4'd0, 32'hAB, 0);
    cycle();
    idle();
    #1;
    chk("basic_cv", commit_valid, 1);
    chk("basic_dest", commit_dest, 5);
    chk("basic_regwrite", RegWrite, 1);
    chk("basic_value", commit_value, 32'hAB);
    cycle();

    // Fill, refuse 17th, commit frees slot 0 for next allocation
    do_reset();
    for (int i = 0; i < 16; i++) begin
      set_issue(1, 5'(i + 1), 0);
      cycle();
    end
    chk("full_flag", rob_full, 1);
    chk("full_tag_wrap", issue_ROB, 0);
    set_issue(1, 5'd20, 0);
    cycle();
    idle();
    set_cdb(4'd0, 32'h1234, 0);
    cycle();
    idle();
    set_issue(1, 5'd21, 0);
    cycle();
    idle();
    chk("after_commit_not_full", rob_full, 0);
    chk("after_commit_tag0", issue_ROB, 0);
    set_issue(1, 5'd22, 0);
    cycle();
    idle();
    chk("refull", rob_full, 1);

    // Out-of-order writeback, in-order commit
    do_reset();
    for (int i = 0; i < 3; i++) begin
      set_issue(1, 5'(i + 8), 0);
      cycle();
    end
    idle();
    set_cdb(4'd2, 32'h22, 0);
    cycle();
    set_cdb(4'd1, 32'h11, 0);
    cycle();
    idle();
    #1;
    chk("ooo_wait", commit_valid, 0);
    set_cdb(4'd0, 32'h00, 0);
    cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("ooo_cv", commit_valid, 1);
      chk("ooo_order", commit_ROB, 4'(i));
      cycle();
    end
    chk("ooo_drained", commit_valid, 0);

    // Mispredicted branch flushes younger entries
    do_reset();
    for (int i = 0; i < 7; i++) begin
      set_issue(i != 3, 5'(i + 1), 0);
      cycle();
    end
    idle();
    for (int i = 0; i < 4; i++) begin
      set_cdb(4'(i), 32'(i * 3), i == 3);
      cycle();
    end
    idle();
    while (q.size() != 0 && !q[0].mis) cycle();
    #1;
    chk("flush_high", flush, 1);
    chk("flush_rob", commit_ROB, 3);
    set_issue(1, 5'd9, 0);
    cycle();
    idle();
    chk("post_flush_tag", issue_ROB, 0);
    chk("post_flush_cv", commit_valid, 0);
    chk("post_flush_flag", flush, 0);

    // Store and x0 writes
    do_reset();
    set_issue(0, 5'd7, 1);
    cycle();
    set_issue(1, 5'd0, 0);
    cycle();
    idle();
    set_cdb(4'd0, 32'h55, 0);
    cycle();
    set_cdb(4'd1, 32'h66, 0);
    #1;
    chk("store_mem_commit", mem_commit, 1);
    chk("store_regwrite", RegWrite, 0);
    cycle();
    idle();
    #1;
    chk("x0_cv", commit_valid, 1);
    chk("x0_regwrite", RegWrite, 0);
    cycle();

    // Lookup of a done but not retired entry
    do_reset();
    set_issue(1, 5'd3, 0);
    cycle();
    set_issue(1, 5'd4, 0);
    cycle();
    idle();
    set_cdb(4'd1, 32'hBEEF, 0);
    cycle();
    idle();
    lk_tag_j = 4'd1;
    lk_tag_k = 4'd0;
    cycle();

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      idle();
      reset          = ($urandom_range(299) == 0);
      issue_valid    = $urandom_range(3) != 0;
      issue_writes   = $urandom_range(1);
      issue_dest     = 5'($urandom_range(31));
      issue_is_store = $urandom_range(3) == 0;
      stall          = $urandom_range(4) == 0;
      cdb_valid      = $urandom_range(1);
      if (q.size() != 0 && $urandom_range(7) != 0)
        cdb_ROB = q[$urandom_range(q.size() - 1)].tag;
      else
        cdb_ROB = 4'($urandom_range(15));
      cdb_value      = $urandom;
      cdb_mispredict = $urandom_range(24) == 0;
      lk_tag_j       = 4'($urandom_range(15));
      lk_tag_k       = 4'($urandom_range(15));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
